ble_tx_sequencer: RTL and testbench

Framing controller that sits in front of the whitening stage on the BLE transmit path. For each packet it:
- emits the preamble and access address with the whitener bypassed;
- re-initialises the whitener with the packet's channel index;
- streams the PDU+CRC bits from upstream through the whitener;
- reports completion once the whitener has delivered the final bit.

---
 rtl/ble_tx_sequencer.sv | 161 ++++++++++++++++
 tb/tb_ble_tx_sequencer.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ble_tx_sequencer.sv
// BLE transmit framing controller: sends preamble and access address with the whitener
// bypassed, reseeds the whitener with the channel, then streams PDU+CRC bits through it.
module ble_tx_sequencer (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        start,
    input  logic [5:0]  channel,
    input  logic [31:0] access_addr,
    output logic        busy,
    output logic        done,
    input  logic        s_tdata,
    input  logic        s_tvalid,
    input  logic        s_tlast,
    output logic        s_tready,
    output logic        m_tdata,
    output logic        m_tvalid,
    output logic        m_tlast,
    input  logic        m_tready,
    output logic        whit_bypass,
    output logic        whit_restart,
    output logic [5:0]  whit_channel,
    input  logic        mon_tvalid,
    input  logic        mon_tready,
    input  logic        mon_tlast
);

    typedef enum logic [2:0] {
        IDLE,
        PREAMBLE,
        AADDR,
        REINIT,
        PAYLOAD,
        DRAIN
    } state_t;

    state_t      state;
    state_t      next_state;
    logic [5:0]  bit_cnt;
    logic [31:0] shift_reg;
    logic [31:0] aa_reg;
    logic [5:0]  chan_reg;
    logic        done_reg;
    logic [7:0]  preamble;
    logic        beat;
    logic        last_seen;

    // The last preamble bit must differ from the first access-address bit.
    assign preamble  = access_addr[0] ? 8'h55 : 8'hAA;
    assign beat      = m_tvalid && m_tready;
    assign last_seen = mon_tvalid && mon_tready && mon_tlast;

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            shift_reg <= '0;
            aa_reg    <= '0;
            chan_reg  <= '0;
            done_reg  <= 1'b0;
        end else begin
            state    <= next_state;
            done_reg <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        chan_reg  <= channel;
                        aa_reg    <= access_addr;
                        shift_reg <= {24'h000000, preamble};
                        bit_cnt   <= '0;
                    end
                end
                PREAMBLE: begin
                    if (beat) begin
                        if (bit_cnt == 6'd7) begin
                            shift_reg <= aa_reg;
                            bit_cnt   <= '0;
                        end else begin
                            shift_reg <= {1'b0, shift_reg[31:1]};
                            bit_cnt   <= bit_cnt + 6'd1;
                        end
                    end
                end
                AADDR: begin
                    if (beat) begin
                        shift_reg <= {1'b0, shift_reg[31:1]};
                        bit_cnt   <= (bit_cnt == 6'd31) ? 6'd0 : bit_cnt + 6'd1;
                    end
                end
                // done is held one cycle in DRAIN so busy drops only after the pulse.
                DRAIN: begin
                    if (!done_reg && last_seen) begin
                        done_reg <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        next_state   = state;
        m_tdata      = 1'b0;
        m_tvalid     = 1'b0;
        m_tlast      = 1'b0;
        s_tready     = 1'b0;
        whit_bypass  = 1'b0;
        whit_restart = 1'b0;
        case (state)
            IDLE: begin
                whit_bypass = 1'b1;
                if (start) begin
                    next_state = PREAMBLE;
                end
            end
            PREAMBLE: begin
                whit_bypass = 1'b1;
                m_tvalid    = 1'b1;
                m_tdata     = shift_reg[0];
                if (m_tready && bit_cnt == 6'd7) begin
                    next_state = AADDR;
                end
            end
            AADDR: begin
                whit_bypass = 1'b1;
                m_tvalid    = 1'b1;
                m_tdata     = shift_reg[0];
                if (m_tready && bit_cnt == 6'd31) begin
                    next_state = REINIT;
                end
            end
            // The whitener LFSR advanced during bypassed beats, so it is reseeded here.
            REINIT: begin
                whit_restart = 1'b1;
                next_state   = PAYLOAD;
            end
            PAYLOAD: begin
                m_tdata  = s_tdata;
                m_tvalid = s_tvalid;
                m_tlast  = s_tlast;
                s_tready = m_tready;
                if (s_tvalid && m_tready && s_tlast) begin
                    next_state = DRAIN;
                end
            end
            DRAIN: begin
                if (done_reg) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    assign busy         = (state != IDLE);
    assign done         = done_reg;
    assign whit_channel = chan_reg;

endmodule

// File: tb/tb_ble_tx_sequencer.sv
// Bench for ble_tx_sequencer: a packet-level model checked every cycle, a bench-side
// whitener driven by the DUT, and directed packets with literal expectations.
module tb_ble_tx_sequencer;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic        start = 1'b0;
    logic [5:0]  channel = '0;
    logic [31:0] access_addr = '0;
    logic        busy;
    logic        done;
    logic        s_tdata = 1'b0;
    logic        s_tvalid = 1'b0;
    logic        s_tlast = 1'b0;
    logic        s_tready;
    logic        m_tdata;
    logic        m_tvalid;
    logic        m_tlast;
    logic        m_tready = 1'b1;
    logic        whit_bypass;
    logic        whit_restart;
    logic [5:0]  whit_channel;
    logic        mon_tvalid;
    logic        mon_tready = 1'b1;
    logic        mon_tlast;

    int vectors = 0;
    int miscompares = 0;

    always #5 aclk = ~aclk;

    ble_tx_sequencer dut (
        .aclk         (aclk),
        .aresetn      (aresetn),
        .start        (start),
        .channel      (channel),
        .access_addr  (access_addr),
        .busy         (busy),
        .done         (done),
        .s_tdata      (s_tdata),
        .s_tvalid     (s_tvalid),
        .s_tlast      (s_tlast),
        .s_tready     (s_tready),
        .m_tdata      (m_tdata),
        .m_tvalid     (m_tvalid),
        .m_tlast      (m_tlast),
        .m_tready     (m_tready),
        .whit_bypass  (whit_bypass),
        .whit_restart (whit_restart),
        .whit_channel (whit_channel),
        .mon_tvalid   (mon_tvalid),
        .mon_tready   (mon_tready),
        .mon_tlast    (mon_tlast)
    );

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Bench whitener: BLE x^7+x^4+1 LFSR, advancing on every input beat, bypassed or not.
    logic [6:0] lfsr = '0;
    logic       wh_valid = 1'b0;
    logic       wh_last = 1'b0;
    bit         wq[$];
    assign mon_tvalid = wh_valid;
    assign mon_tlast  = wh_last;

    always @(posedge aclk) begin
        if (!aresetn) begin
            wh_valid <= 1'b0;
            wh_last  <= 1'b0;
        end else if (whit_restart) begin
            lfsr     <= {whit_channel[0], whit_channel[1], whit_channel[2],
                         whit_channel[3], whit_channel[4], whit_channel[5], 1'b1};
            wh_valid <= 1'b0;
        end else if (m_tvalid && m_tready) begin
            if (!whit_bypass) wq.push_back(m_tdata ^ lfsr[6]);
            lfsr     <= {lfsr[5], lfsr[4], lfsr[3] ^ lfsr[6], lfsr[2], lfsr[1], lfsr[0], lfsr[6]};
            wh_valid <= 1'b1;
            wh_last  <= m_tlast;
        end else if (mon_tready) begin
            wh_valid <= 1'b0;
        end
    end

    bit cap[$];
    int cyc = 0;
    int hs_cyc = -10;
    always @(posedge aclk) begin
        if (aresetn && m_tvalid && m_tready && whit_bypass) cap.push_back(m_tdata);
        if (mon_tvalid && mon_tready && mon_tlast) hs_cyc = cyc;
        cyc = cyc + 1;
    end

    logic bp_mode = 1'b0;
    always @(posedge aclk) begin
        #1;
        m_tready = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Packet-level model: framing bits held in a queue, phases tracked as plain integers.
    localparam int PH_IDLE = 0, PH_FRAME = 1, PH_RESTART = 2, PH_PAYLOAD = 3, PH_DRAIN = 4;
    int         ph = PH_IDLE;
    bit         bq[$];
    logic [5:0] e_chan = '0;
    logic       e_done = 1'b0;

    always @(posedge aclk) begin : model_step
        logic [7:0] pre;
        if (!aresetn) begin
            ph = PH_IDLE;
            bq.delete();
            e_chan = '0;
            e_done = 1'b0;
        end else begin
            case (ph)
                PH_IDLE: if (start) begin
                    pre = access_addr[0] ? 8'h55 : 8'hAA;
                    for (int i = 0; i < 8; i++) bq.push_back(pre[i]);
                    for (int i = 0; i < 32; i++) bq.push_back(access_addr[i]);
                    e_chan = channel;
                    ph = PH_FRAME;
                end
                PH_FRAME: if (m_tready) begin
                    void'(bq.pop_front());
                    if (bq.size() == 0) ph = PH_RESTART;
                end
                PH_RESTART: ph = PH_PAYLOAD;
                PH_PAYLOAD: if (s_tvalid && m_tready && s_tlast) ph = PH_DRAIN;
                PH_DRAIN: begin
                    if (e_done) begin
                        e_done = 1'b0;
                        ph = PH_IDLE;
                    end else if (mon_tvalid && mon_tready && mon_tlast) begin
                        e_done = 1'b1;
                    end
                end
                default: ph = PH_IDLE;
            endcase
        end
    end

    logic chk_en = 1'b0;
    always @(negedge aclk) begin
        if (chk_en) begin
            check_output("busy", busy, ph != PH_IDLE);
            check_output("done", done, e_done);
            check_output("whit_bypass", whit_bypass, ph == PH_IDLE || ph == PH_FRAME);
            check_output("whit_restart", whit_restart, ph == PH_RESTART);
            check_output("whit_channel", whit_channel, e_chan);
            check_output("m_tvalid", m_tvalid, (ph == PH_FRAME) ? 1'b1 : (ph == PH_PAYLOAD) ? s_tvalid : 1'b0);
            check_output("m_tdata", m_tdata, (ph == PH_FRAME) ? bq[0] : (ph == PH_PAYLOAD) ? s_tdata : 1'b0);
            check_output("m_tlast", m_tlast, (ph == PH_PAYLOAD) ? s_tlast : 1'b0);
            check_output("s_tready", s_tready, (ph == PH_PAYLOAD) ? m_tready : 1'b0);
        end
    end

    function automatic logic [31:0] cap_bits(int first, int n);
        logic [31:0] v = '0;
        for (int i = 0; i < n; i++) if (first + i < cap.size()) v[i] = cap[first + i];
        return v;
    endfunction

    function automatic logic [31:0] wq_bits(int n);
        logic [31:0] v = '0;
        for (int i = 0; i < n; i++) if (i < wq.size()) v[i] = wq[i];
        return v;
    endfunction

    task automatic apply_start(input logic [31:0] aa, input logic [5:0] ch);
        cap.delete();
        wq.delete();
        @(posedge aclk);
        #1;
        start = 1'b1;
        access_addr = aa;
        channel = ch;
        @(posedge aclk);
        #1;
        start = 1'b0;
        access_addr = ~aa;
        channel = ~ch;
    endtask

    task automatic apply_payload(input logic [15:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            int t = 0;
            s_tvalid = 1'b1;
            s_tdata  = bits[i];
            s_tlast  = (i == n - 1);
            @(negedge aclk);
            while (!s_tready && t < 200) begin
                @(negedge aclk);
                t++;
            end
            check_output("payload_accept", s_tready, 1);
            @(posedge aclk);
            #1;
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        s_tdata  = 1'b0;
    endtask

    task automatic wait_cap(input string name);
        int t = 0;
        while (cap.size() < 40 && t < 1000) begin
            @(negedge aclk);
            t++;
        end
        check_output({name, "_beats"}, cap.size(), 40);
    endtask

    task automatic wait_done(input string name);
        int t = 0;
        @(negedge aclk);
        while (!done && t < 100) begin
            @(negedge aclk);
            t++;
        end
        check_output({name, "_done"}, done, 1);
        check_output({name, "_done_after_hs"}, cyc - hs_cyc, 1);
        @(posedge aclk);
        #1;
    endtask

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        aresetn = 1'b0;
        @(posedge aclk);
        #1;
        chk_en = 1'b1;
        @(posedge aclk);
        @(negedge aclk);
        check_output("rst_busy", busy, 0);
        check_output("rst_bypass", whit_bypass, 1);
        check_output("rst_m_tvalid", m_tvalid, 0);
        check_output("rst_channel", whit_channel, 0);
        aresetn = 1'b1;

        // Standard advertising access address on channel 37 with 16 zero payload bits.
        apply_start(32'h8E89BED6, 6'd37);
        repeat (40) @(posedge aclk);
        @(negedge aclk);
        check_output("t1_restart", whit_restart, 1);
        check_output("t1_channel", whit_channel, 37);
        check_output("t1_beats", cap.size(), 40);
        check_output("t1_preamble", cap_bits(0, 8), 32'h000000AA);
        check_output("t1_aa", cap_bits(8, 32), 32'h8E89BED6);
        apply_payload(16'h0000, 16);
        wait_done("t1");
        check_output("t1_white_len", wq.size(), 16);
        check_output("t1_whitened", wq_bits(16), 32'h0000D28D);

        // Access address LSB set, then a single-bit payload.
        apply_start(32'h00000001, 6'd5);
        wait_cap("t2");
        check_output("t2_preamble", cap_bits(0, 8), 32'h00000055);
        check_output("t2_aa", cap_bits(8, 32), 32'h00000001);
        apply_payload(16'h0001, 1);
        wait_done("t2");

        // Random backpressure on the framing bits.
        apply_start(32'hC3A50F96, 6'd12);
        bp_mode = 1'b1;
        wait_cap("t3");
        bp_mode = 1'b0;
        check_output("t3_preamble", cap_bits(0, 8), 32'h000000AA);
        check_output("t3_aa", cap_bits(8, 32), 32'hC3A50F96);
        apply_payload(16'h000B, 4);
        wait_done("t3");

        // start and new channel/address while in PAYLOAD are ignored.
        apply_start(32'h12345678, 6'd20);
        repeat (41) @(posedge aclk);
        #1;
        start = 1'b1;
        channel = 6'd3;
        access_addr = 32'h0;
        @(posedge aclk);
        #1;
        start = 1'b0;
        @(negedge aclk);
        check_output("t4_busy", busy, 1);
        check_output("t4_channel", whit_channel, 20);
        check_output("t4_bypass", whit_bypass, 0);
        apply_payload(16'h00A5, 8);
        wait_done("t4");

        // Reset at access-address bit 10, then a full replay.
        apply_start(32'h8E89BED6, 6'd37);
        repeat (18) @(posedge aclk);
        #1;
        aresetn = 1'b0;
        @(posedge aclk);
        #1;
        @(negedge aclk);
        check_output("t5_m_tvalid", m_tvalid, 0);
        check_output("t5_m_tdata", m_tdata, 0);
        check_output("t5_busy", busy, 0);
        check_output("t5_bypass", whit_bypass, 1);
        check_output("t5_channel", whit_channel, 0);
        check_output("t5_s_tready", s_tready, 0);
        aresetn = 1'b1;
        apply_start(32'h00000001, 6'd9);
        wait_cap("t5");
        check_output("t5_preamble", cap_bits(0, 8), 32'h00000055);
        check_output("t5_aa", cap_bits(8, 32), 32'h00000001);
        apply_payload(16'h0002, 2);
        wait_done("t5");

        repeat (3) @(posedge aclk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
